// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for four bus masters with hold-timeout preemption
module bus_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] m_req_,
    input  logic [3:0] m_as_,
    output logic [3:0] m_grnt_,
    output logic [1:0] owner,
    output logic       bus_busy,
    output logic       preempt
);
    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [1:0]        last, last_nx, owner_nx;
    logic [3:0]        grnt_nx;
    logic              busy_nx, preempt_nx;
    logic [3:0]        req, others;
    logic              idle_found, own_found;
    logic [1:0]        idle_win, own_win;

    // Returns {found, index}; scans base+1, base+2, base+3, base so base has lowest priority.
    function automatic logic [2:0] rr_scan(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign req    = ~m_req_;
    assign others = req & ~(4'b0001 << owner);

    assign {idle_found, idle_win} = rr_scan(req, last);
    // The owner is masked out, so a preemption can never re-grant the revoked master.
    assign {own_found, own_win}   = rr_scan(others, owner);

    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        last_nx    = last;
        owner_nx   = owner;
        grnt_nx    = m_grnt_;
        busy_nx    = bus_busy;
        preempt_nx = 1'b0;
        case (state)
            IDLE: begin
                if (idle_found) begin
                    grnt_nx  = ~(4'b0001 << idle_win);
                    owner_nx = idle_win;
                    busy_nx  = 1'b1;
                    hold_nx  = '0;
                    state_nx = OWNED;
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    // Release has priority over a coincident timeout.
                    last_nx = owner;
                    hold_nx = '0;
                    if (own_found) begin
                        grnt_nx  = ~(4'b0001 << own_win);
                        owner_nx = own_win;
                    end else begin
                        grnt_nx  = 4'b1111;
                        busy_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end else if (own_found) begin
                    if (hold_cnt == HOLD_LAST && m_as_[owner]) begin
                        last_nx    = owner;
                        grnt_nx    = ~(4'b0001 << own_win);
                        owner_nx   = own_win;
                        preempt_nx = 1'b1;
                        hold_nx    = '0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                end else begin
                    hold_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            m_grnt_  <= 4'b1111;
            owner    <= 2'd0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            last     <= 2'd3;
        end else begin
            state    <= state_nx;
            m_grnt_  <= grnt_nx;
            owner    <= owner_nx;
            bus_busy <= busy_nx;
            preempt  <= preempt_nx;
            hold_cnt <= hold_nx;
            last     <= last_nx;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with a behavioural model
module tb_bus_arbiter;
    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       reset;
    logic [3:0] m_req_;
    logic [3:0] m_as_;
    logic [3:0] m_grnt_;
    logic [1:0] owner;
    logic       bus_busy;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 = bus free), rotation pointer, contention cycles, visible owner.
    int md_owner = -1;
    int md_last  = 3;
    int md_wait  = 0;
    int md_sel   = 0;
    bit md_pre   = 0;

    bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_as_(m_as_),
        .m_grnt_(m_grnt_), .owner(owner), .bus_busy(bus_busy), .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [3:0] r, input int base);
        for (int k = 1; k <= 4; k++) begin
            if (r[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_grnt();
        logic [3:0] g;
        g = 4'b1111;
        if (md_owner >= 0) g[md_owner] = 1'b0;
        return g;
    endfunction

    function automatic int lows(input logic [3:0] g);
        return (g[0] ? 0 : 1) + (g[1] ? 0 : 1) + (g[2] ? 0 : 1) + (g[3] ? 0 : 1);
    endfunction

    // Advance one clock edge and apply the arbitration rules to the model.
    task automatic step();
        logic [3:0] r, a, oth;
        logic rs;
        int w;
        r = ~m_req_; a = m_as_; rs = reset;
        @(posedge clk);
        #1;
        md_pre = 0;
        if (rs) begin
            md_owner = -1; md_last = 3; md_wait = 0; md_sel = 0;
        end else if (md_owner < 0) begin
            w = rr_pick(r, md_last);
            if (w >= 0) begin md_owner = w; md_sel = w; md_wait = 0; end
        end else begin
            oth = r;
            oth[md_owner] = 1'b0;
            if (!r[md_owner]) begin
                md_last = md_owner; md_wait = 0;
                md_owner = rr_pick(oth, md_last);
                if (md_owner >= 0) md_sel = md_owner;
            end else if (oth != 0) begin
                if (md_wait >= MAX_HOLD - 1 && a[md_owner]) begin
                    md_last = md_owner; md_wait = 0; md_pre = 1;
                    md_owner = rr_pick(oth, md_last);
                    md_sel = md_owner;
                end else if (md_wait < MAX_HOLD - 1) begin
                    md_wait++;
                end
            end else begin
                md_wait = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; m_req_ = 4'b1111; m_as_ = 4'b1111;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        m_req_ = 4'b0000; m_as_ = 4'b1111; reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (m_grnt_ !== 4'b1111) begin bad++; $display("FAIL reset_grnt got=%b exp=1111", m_grnt_); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
        total++; if (preempt !== 1'b0) begin bad++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
    endtask

    task automatic test_single();
        do_reset();
        m_req_ = 4'b1101;
        step();
        total++; if (m_grnt_ !== 4'b1101) begin bad++; $display("FAIL single_grnt got=%b exp=1101", m_grnt_); end
        total++; if (owner !== 2'd1) begin bad++; $display("FAIL single_owner got=%0d exp=1", owner); end
        total++; if (bus_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus_busy); end
        m_req_ = 4'b1111;
        step();
        total++; if (m_grnt_ !== 4'b1111) begin bad++; $display("FAIL single_release_grnt got=%b exp=1111", m_grnt_); end
        total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL single_release_busy got=%b exp=0", bus_busy); end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] eg;
        do_reset();
        m_req_ = 4'b0000;
        step();
        for (int n = 0; n < 5; n++) begin
            eg = 4'b1111;
            eg[order[n]] = 1'b0;
            for (int t = 0; t < 3; t++) begin
                total++; if (m_grnt_ !== eg || owner !== 2'(order[n]))
                    begin bad++; $display("FAIL rotation n=%0d t=%0d got grnt=%b owner=%0d exp grnt=%b owner=%0d", n, t, m_grnt_, owner, eg, order[n]); end
                total++; if (lows(m_grnt_) != 1) begin bad++; $display("FAIL rotation_onehot got=%b exp=one low bit", m_grnt_); end
                if (t == 2) begin
                    m_req_ = 4'b0000;
                    m_req_[order[n]] = 1'b1;
                end
                step();
                m_req_ = 4'b0000;
            end
        end
    endtask

    task automatic test_preempt();
        do_reset();
        m_req_ = 4'b1101;
        step();
        m_req_ = 4'b1100;
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
            total++; if (preempt !== 1'b0 || m_grnt_ !== 4'b1101)
                begin bad++; $display("FAIL preempt_early i=%0d got pre=%b grnt=%b exp pre=0 grnt=1101", i, preempt, m_grnt_); end
        end
        step();
        total++; if (preempt !== 1'b1 || m_grnt_ !== 4'b1110 || owner !== 2'd0)
            begin bad++; $display("FAIL preempt_fire got pre=%b grnt=%b owner=%0d exp pre=1 grnt=1110 owner=0", preempt, m_grnt_, owner); end
        step();
        total++; if (preempt !== 1'b0) begin bad++; $display("FAIL preempt_pulse got=%b exp=0", preempt); end
        m_req_ = 4'b1101;
        step();
        total++; if (m_grnt_ !== 4'b1101 || owner !== 2'd1)
            begin bad++; $display("FAIL preempt_regrant got grnt=%b owner=%0d exp grnt=1101 owner=1", m_grnt_, owner); end
    endtask

    task automatic test_as_block();
        do_reset();
        m_req_ = 4'b1101;
        step();
        m_req_ = 4'b1100;
        m_as_  = 4'b1101;
        for (int i = 1; i < 12; i++) begin
            step();
            total++; if (preempt !== 1'b0 || owner !== 2'd1)
                begin bad++; $display("FAIL as_block i=%0d got pre=%b owner=%0d exp pre=0 owner=1", i, preempt, owner); end
        end
        m_as_ = 4'b1111;
        step();
        total++; if (preempt !== 1'b1 || m_grnt_ !== 4'b1110)
            begin bad++; $display("FAIL as_release got pre=%b grnt=%b exp pre=1 grnt=1110", preempt, m_grnt_); end
    endtask

    task automatic test_release_timeout();
        do_reset();
        m_req_ = 4'b1101;
        step();
        m_req_ = 4'b1000;
        for (int i = 1; i < MAX_HOLD; i++) step();
        m_req_ = 4'b1010;
        step();
        total++; if (preempt !== 1'b0 || m_grnt_ !== 4'b1011 || owner !== 2'd2)
            begin bad++; $display("FAIL release_timeout got pre=%b grnt=%b owner=%0d exp pre=0 grnt=1011 owner=2", preempt, m_grnt_, owner); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_req_ = 4'b1011;
        step();
        total++; if (owner !== 2'd2) begin bad++; $display("FAIL mid_owner2 got=%0d exp=2", owner); end
        m_req_ = 4'b0000;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (m_grnt_ !== 4'b1111 || owner !== 2'd0 || preempt !== 1'b0 || bus_busy !== 1'b0)
            begin bad++; $display("FAIL mid_reset got grnt=%b owner=%0d pre=%b busy=%b exp 1111/0/0/0", m_grnt_, owner, preempt, bus_busy); end
        step();
        total++; if (m_grnt_ !== 4'b1110 || owner !== 2'd0)
            begin bad++; $display("FAIL mid_after got grnt=%b owner=%0d exp grnt=1110 owner=0", m_grnt_, owner); end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) m_req_[b] = ~m_req_[b];
            m_as_ = 4'($urandom);
            step();
            eg = model_grnt();
            total++; if (m_grnt_ !== eg || owner !== 2'(md_sel) || bus_busy !== (md_owner >= 0) || preempt !== md_pre)
                begin bad++; $display("FAIL random c=%0d got grnt=%b owner=%0d busy=%b pre=%b exp grnt=%b owner=%0d busy=%b pre=%b",
                    c, m_grnt_, owner, bus_busy, preempt, eg, md_sel, md_owner >= 0, md_pre); end
            total++; if (lows(m_grnt_) > 1) begin bad++; $display("FAIL random_onehot c=%0d got=%b exp=at most one low", c, m_grnt_); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; m_req_ = 4'b1111; m_as_ = 4'b1111;
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_as_block();
        test_release_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
